// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared glyph table and scan state encoding for the 7-segment display blocks
package sevenseg_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, GAP = 2'd1, ON = 2'd2} state_e;
  // Active-high glyphs {g,f,e,d,c,b,a}; 6, 7 and 9 carry their tail segments
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/sevenseg_scan_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-high 7-segment glyph
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed common-anode 7-segment driver with dead gap and leading-zero blanking
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZ_BLANK     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clk,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  output logic              frame,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp
);
  localparam int IW = $clog2(NDIG);
  localparam int GW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic POL = ACTIVE_LOW != 0;
  logic s1_q, s2_q, s3_q, tick_q;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [4*NDIG-1:0] sdig_q, sdig_d;
  logic [NDIG-1:0] sdp_q, sdp_d, an_d;
  logic adv, wrap, on, blank, dp_d;
  logic [3:0] nib;
  logic [6:0] glyph, seg_d;
  hex_to_seg u_dec (.nib_i(nib), .seg_o(glyph));
  // Outputs are computed from next-state so they change on the very edge that enters/leaves ON
  always_comb begin
    adv = tick_q && state_q != GAP;
    wrap = adv && idx_q == IW'(NDIG - 1);
    idx_d = adv ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    sdig_d = wrap ? digits : sdig_q;
    sdp_d = wrap ? dp_in : sdp_q;
    state_d = state_q;
    gcnt_d = gcnt_q;
    if (adv) begin
      state_d = (BLANK_CYCLES == 0) ? ON : GAP;
      gcnt_d = GW'(BLANK_CYCLES - 1);
    end else if (state_q == GAP) begin
      state_d = (gcnt_q == '0) ? ON : GAP;
      gcnt_d = (gcnt_q == '0) ? gcnt_q : gcnt_q - 1'b1;
    end
    nib = sdig_d[4*idx_d +: 4];
    blank = LZ_BLANK != 0 && idx_d != '0;
    for (int i = 0; i < NDIG; i++)
      if (i >= int'(idx_d) && sdig_d[4*i +: 4] != 4'd0) blank = 1'b0;
    on = state_d == ON;
    an_d = on ? NDIG'(1) << idx_d : '0;
    seg_d = (on && !blank) ? glyph : 7'd0;
    dp_d = on && sdp_d[idx_d];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      tick_q <= 1'b0;
      state_q <= OFF;
      idx_q <= IW'(NDIG - 1);
      gcnt_q <= '0;
      sdig_q <= '0;
      sdp_q <= '0;
      frame <= 1'b0;
      an <= {NDIG{POL}};
      seg <= {7{POL}};
      dp <= POL;
    end else begin
      s1_q <= div_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
      tick_q <= s2_q & ~s3_q;
      state_q <= state_d;
      idx_q <= idx_d;
      gcnt_q <= gcnt_d;
      sdig_q <= sdig_d;
      sdp_q <= sdp_d;
      frame <= wrap;
      an <= an_d ^ {NDIG{POL}};
      seg <= seg_d ^ {7{POL}};
      dp <= dp_d ^ POL;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed checks of scan order, gaps, blanking, shadowing, glitch drop and reset
module tb_sevenseg_scan;
  logic clk = 1'b0, rst = 1'b1, div_clk = 1'b0, div_clk2 = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0] dp_in = 4'h0;
  logic frame, dp, frame2, dp2;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  int total = 0, bad = 0, frame_cnt = 0;
  always #5 clk = ~clk;
  sevenseg_scan #(.NDIG(4), .BLANK_CYCLES(8), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .digits(digits), .dp_in(dp_in),
    .frame(frame), .an(an), .seg(seg), .dp(dp));
  sevenseg_scan #(.NDIG(4), .BLANK_CYCLES(20), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut2 (
    .clk(clk), .rst(rst), .div_clk(div_clk2), .digits(digits), .dp_in(dp_in),
    .frame(frame2), .an(an2), .seg(seg2), .dp(dp2));
  always @(negedge clk) if (frame === 1'b1) frame_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic next_digit(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                            input logic edp, input bit chk_gap);
    int n = 0, g = 0;
    bit seen_off;
    @(negedge clk) div_clk = 1'b1;
    repeat (3) @(negedge clk);
    div_clk = 1'b0;
    seen_off = (an == 4'hF);
    while (n < 100 && !(seen_off && an != 4'hF)) begin
      @(negedge clk);
      n++;
      if (an == 4'hF) begin
        seen_off = 1'b1;
        g++;
      end
    end
    chk({tag, "_timeout"}, n < 100, 1);
    chk({tag, "_out"}, {an, seg, dp}, {ean, eseg, edp});
    if (chk_gap) chk({tag, "_gap"}, g, 8);
  endtask
  task automatic pulse_rst(input string tag);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk(tag, {an, seg, dp, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
  endtask
  initial begin
    int n;
    repeat (3) begin
      @(negedge clk);
      chk("reset", {an, seg, dp, frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    digits = 16'h12AF;
    dp_in = 4'b0100;
    rst = 1'b0;
    next_digit("d0_F", 4'b1110, 7'h0E, 1'b1, 1'b0);
    next_digit("d1_A", 4'b1101, 7'h08, 1'b1, 1'b1);
    next_digit("d2_2", 4'b1011, 7'h24, 1'b0, 1'b1);
    next_digit("d3_1", 4'b0111, 7'h79, 1'b1, 1'b1);
    chk("frame_once", frame_cnt, 1);
    digits = 16'h0050;
    dp_in = 4'b0000;
    next_digit("lz_d0", 4'b1110, 7'h40, 1'b1, 1'b1);
    next_digit("lz_d1", 4'b1101, 7'h12, 1'b1, 1'b1);
    digits = 16'h8000;
    next_digit("lz_d2", 4'b1011, 7'h7F, 1'b1, 1'b1);
    next_digit("lz_d3", 4'b0111, 7'h7F, 1'b1, 1'b1);
    chk("frame_hold", frame_cnt, 2);
    next_digit("new_d0", 4'b1110, 7'h40, 1'b1, 1'b1);
    chk("frame_new", frame_cnt, 3);
    next_digit("new_d1", 4'b1101, 7'h40, 1'b1, 1'b1);
    next_digit("new_d2", 4'b1011, 7'h40, 1'b1, 1'b1);
    next_digit("new_d3", 4'b0111, 7'h00, 1'b1, 1'b1);
    @(negedge clk) div_clk2 = 1'b1;
    repeat (2) @(negedge clk);
    div_clk2 = 1'b0;
    n = 0;
    while (n < 20 && frame2 !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_first_tick", n < 20, 1);
    repeat (3) begin
      @(negedge clk) div_clk2 = 1'b1;
      @(negedge clk) div_clk2 = 1'b0;
    end
    n = 0;
    while (n < 40 && an2 == 4'hF) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_on", {an2, seg2}, {4'b1110, 7'h40});
    repeat (30) @(negedge clk);
    chk("glitch_hold", an2, 4'b1110);
    @(negedge clk) div_clk2 = 1'b1;
    repeat (3) @(negedge clk);
    div_clk2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_next", an2, 4'b1101);
    @(negedge clk) div_clk = 1'b1;
    repeat (3) @(negedge clk);
    div_clk = 1'b0;
    n = 0;
    while (n < 20 && an != 4'hF) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    pulse_rst("rst_gap");
    repeat (20) @(negedge clk);
    chk("rst_gap_idle", an, 4'hF);
    digits = 16'h0003;
    dp_in = 4'b0001;
    n = frame_cnt;
    next_digit("rg_d0", 4'b1110, 7'h30, 1'b0, 1'b0);
    chk("rg_frame", frame_cnt, n + 1);
    next_digit("rg_d1", 4'b1101, 7'h7F, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    pulse_rst("rst_on");
    digits = 16'h00C0;
    dp_in = 4'b0000;
    next_digit("ro_d0", 4'b1110, 7'h40, 1'b1, 1'b0);
    next_digit("ro_d1", 4'b1101, 7'h46, 1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
